// File: rtl/gray_mon_pkg.sv
// -----------------------------------------------------------------------------
// gray_mon_pkg
// Shared types and default widths for the Gray-stream monitor.
//   state_t : monitor FSM state, 2-bit encoding
//   GRAY_W  : default Gray code width
//   LAP_W   : default lap counter width
//   ERR_W   : default error counter width (GRAY_MON_ERRCNT_EN builds only)
// -----------------------------------------------------------------------------
package gray_mon_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,  // no reference sample held yet
        S_TRACK = 2'b01,  // checking each step against the previous sample
        S_FAULT = 2'b10   // an illegal step was seen; convert only
    } state_t;

    localparam int GRAY_W = 3;
    localparam int LAP_W  = 8;
    localparam int ERR_W  = 4;

endpackage

// File: rtl/gray_monitor_if.sv
// -----------------------------------------------------------------------------
// gray_monitor_if
// Bundles the Gray sample stream and the monitor's status outputs.
//   master : upstream/consumer side (drives in_valid, gray_in; reads status)
//   slave  : the monitor (reads the stream; drives status)
// Signals:
//   in_valid, gray_in         : sample stream from the Gray counter
//   bin_out, bin_valid        : binary position and its update pulse
//   lap_cnt, lap_pulse        : forward-wrap count and its pulse
//   step_err, err_sticky      : first-illegal-step pulse and sticky flag
//   err_cnt                   : saturating illegal-step count, present only
//                               when GRAY_MON_ERRCNT_EN is defined
// -----------------------------------------------------------------------------
interface gray_monitor_if #(
    parameter int WIDTH = gray_mon_pkg::GRAY_W,
    parameter int LAP_W = gray_mon_pkg::LAP_W
`ifdef GRAY_MON_ERRCNT_EN
    , parameter int ERR_W = gray_mon_pkg::ERR_W
`endif
);

    logic             in_valid;
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] bin_out;
    logic             bin_valid;
    logic [LAP_W-1:0] lap_cnt;
    logic             lap_pulse;
    logic             step_err;
    logic             err_sticky;
`ifdef GRAY_MON_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt;
`endif

    modport master (
        output in_valid, gray_in,
        input  bin_out, bin_valid, lap_cnt, lap_pulse, step_err, err_sticky
`ifdef GRAY_MON_ERRCNT_EN
        , err_cnt
`endif
    );

    modport slave (
        input  in_valid, gray_in,
        output bin_out, bin_valid, lap_cnt, lap_pulse, step_err, err_sticky
`ifdef GRAY_MON_ERRCNT_EN
        , err_cnt
`endif
    );

endinterface

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter.
//   gray : Gray-coded input, WIDTH bits
//   bin  : binary equivalent, WIDTH bits
// Each binary bit is the XOR of all Gray bits at or above its position, which
// is the unrolled form of bin[i] = bin[i+1] ^ gray[i] with bin[MSB] = gray[MSB].
// -----------------------------------------------------------------------------
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // or looped assignment, so no path can leave it unassigned (no latch).
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_monitor.sv
// -----------------------------------------------------------------------------
// gray_monitor
// Consumes a Gray counter stream, reports binary position, counts forward laps
// and flags the first illegal step. All outputs are registered and reflect the
// sample accepted at the previous edge; pulses last one cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state
//   clr   : synchronous clear, same effect as reset; wins over in_valid
//   mon   : gray_monitor_if.slave (stream in, status out)
// Optional feature: define GRAY_MON_ERRCNT_EN to add the saturating err_cnt
// output, which counts every illegal step including those seen in S_FAULT.
// -----------------------------------------------------------------------------
module gray_monitor #(
    parameter int WIDTH = gray_mon_pkg::GRAY_W,
    parameter int LAP_W = gray_mon_pkg::LAP_W
`ifdef GRAY_MON_ERRCNT_EN
    , parameter int ERR_W = gray_mon_pkg::ERR_W
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    gray_monitor_if.slave mon
);

    import gray_mon_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] bin_out;
    logic             bin_valid;
    logic [LAP_W-1:0] lap_cnt;
    logic             lap_pulse;
    logic             step_err;
    logic             err_sticky;

    logic [WIDTH-1:0] b_new;
    logic [WIDTH-1:0] b_old;
    logic             is_hold;
    logic             is_inc;
    logic             is_legal;
    logic             is_wrap;
    logic             bad_step;

    gray2bin #(.WIDTH(WIDTH)) u_new (.gray(mon.gray_in), .bin(b_new));
    gray2bin #(.WIDTH(WIDTH)) u_old (.gray(prev_gray),   .bin(b_old));

    // A step is legal if the code holds or advances by exactly +1 (mod 2^WIDTH).
    // Comparing in binary rejects single-bit Gray flips that are not +1.
    assign is_hold  = (mon.gray_in == prev_gray);
    assign is_inc   = (b_new == WIDTH'(b_old + 1'b1));
    assign is_legal = is_hold | is_inc;
    assign is_wrap  = is_inc & (b_old == {WIDTH{1'b1}});

    // Illegal step on an accepted sample once a reference exists.
    assign bad_step = mon.in_valid & (state != S_EMPTY) & ~is_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state      <= S_EMPTY;
            prev_gray  <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            lap_cnt    <= '0;
            lap_pulse  <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            // Clear wins over a coincident sample; that sample is dropped.
            state      <= S_EMPTY;
            prev_gray  <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            lap_cnt    <= '0;
            lap_pulse  <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            bin_valid <= 1'b0;
            lap_pulse <= 1'b0;
            step_err  <= 1'b0;

            if (mon.in_valid) begin
                prev_gray <= mon.gray_in;
                bin_out   <= b_new;
                bin_valid <= 1'b1;

                case (state)
                    S_EMPTY: begin
                        // First sample only seeds the reference.
                        state <= S_TRACK;
                    end
                    S_TRACK: begin
                        if (!is_legal) begin
                            step_err   <= 1'b1;
                            err_sticky <= 1'b1;
                            state      <= S_FAULT;
                        end else if (is_wrap) begin
                            lap_cnt   <= lap_cnt + 1'b1;
                            lap_pulse <= 1'b1;
                        end
                    end
                    S_FAULT: begin
                        // Convert only: no laps, no further step_err pulses.
                        state <= S_FAULT;
                    end
                    default: begin
                        // Unused encoding: recover by re-seeding.
                        state <= S_EMPTY;
                    end
                endcase
            end
        end
    end

`ifdef GRAY_MON_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt;

    // Saturating count of every illegal step, in S_TRACK and S_FAULT alike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (bad_step && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign mon.err_cnt = err_cnt;
`else
    // Without the error counter, illegal steps are only visible via the FSM.
    logic unused_bad_step;
    assign unused_bad_step = bad_step;
`endif

    assign mon.bin_out    = bin_out;
    assign mon.bin_valid  = bin_valid;
    assign mon.lap_cnt    = lap_cnt;
    assign mon.lap_pulse  = lap_pulse;
    assign mon.step_err   = step_err;
    assign mon.err_sticky = err_sticky;

endmodule
